weight_cache_6: RTL



---
 rtl/weight_cache_6_pkg.sv | 15 +
 rtl/weight_cache_6_weight_bank.sv | 28 ++
 rtl/weight_cache_6.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/weight_cache_6_pkg.sv
// Shared types and default sizing for the layer-6 weight cache.
// Defaults mirror the layer-6 sizing: kernel of 4 coefficients, 16-bit data, 3 replays.
// FSM state encoding for the single-bank LOAD/REPLAY controller lives here.
package weight_cache_6_pkg;

  localparam int KERN_S_6      = 4;
  localparam int COEFF_WIDTH   = 16;
  localparam int KERN_REPLAY_6 = 3;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_REPLAY = 1'b1
  } cache_state_e;

endpackage

// File: rtl/weight_cache_6_weight_bank.sv
// Kernel storage: KERN_SIZE x DATA_W register array, one write port, one read port.
// Latency: write lands on the next rising edge; read is combinational from raddr.
// Backpressure: none; the owning controller decides when to write.
module weight_bank #(
  parameter int KERN_SIZE = 4,
  parameter int DATA_W    = 16,
  localparam int AW       = $clog2(KERN_SIZE)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [KERN_SIZE];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/weight_cache_6.sv
// Captures one kernel from the weight FIFO, then replays it REPLAYS times to the MAC FIFO.
// Latency: first replay write possible 1 cycle after the last load; 1 word/cycle each phase.
// Backpressure: read only while loading and upstream non-empty; write holds din while full_n low.
// Optional WEIGHT_CACHE_PINGPONG_EN: two banks so the next kernel loads during replay.
module weight_cache_6
  import weight_cache_6_pkg::*;
#(
  parameter int KERN_SIZE = KERN_S_6,
  parameter int DATA_W    = COEFF_WIDTH,
  parameter int REPLAYS   = KERN_REPLAY_6
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] input_V_dout,
  input  logic              input_V_empty_n,
  output logic              input_V_read,
  output logic [DATA_W-1:0] output_V_din,
  input  logic              output_V_full_n,
  output logic              output_V_write
);

  localparam int AW = $clog2(KERN_SIZE);
  localparam int RW = $clog2(REPLAYS + 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(KERN_SIZE - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPLAYS - 1);

  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          in_xfer;
  logic          out_xfer;

`ifdef WEIGHT_CACHE_PINGPONG_EN

  logic       ld_bank_q, ld_bank_d;
  logic       rp_bank_q, rp_bank_d;
  logic [1:0] full_q, full_d;
  logic [DATA_W-1:0] rdata0, rdata1;

  // Loader only reads into a free bank; replayer only drives from a full one.
  assign input_V_read   = ap_rst_n && input_V_empty_n && !full_q[ld_bank_q];
  assign output_V_write = ap_rst_n && output_V_full_n && full_q[rp_bank_q];
  assign in_xfer        = input_V_read;
  assign out_xfer       = output_V_write;
  assign output_V_din   = rp_bank_q ? rdata1 : rdata0;

  weight_bank #(.KERN_SIZE(KERN_SIZE), .DATA_W(DATA_W)) u_bank0 (
    .clk   (ap_clk),
    .we    (in_xfer && !ld_bank_q),
    .waddr (wr_addr_q),
    .wdata (input_V_dout),
    .raddr (rd_addr_q),
    .rdata (rdata0)
  );

  weight_bank #(.KERN_SIZE(KERN_SIZE), .DATA_W(DATA_W)) u_bank1 (
    .clk   (ap_clk),
    .we    (in_xfer && ld_bank_q),
    .waddr (wr_addr_q),
    .wdata (input_V_dout),
    .raddr (rd_addr_q),
    .rdata (rdata1)
  );

  // Loader and replayer advance independently; a bank filled in the same cycle the
  // other finishes replay is seen full on the next cycle, so there is no bubble.
  always_comb begin
    ld_bank_d = ld_bank_q;
    rp_bank_d = rp_bank_q;
    full_d    = full_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rep_cnt_d = rep_cnt_q;
    if (in_xfer) begin
      if (wr_addr_q == ADDR_LAST) begin
        wr_addr_d         = '0;
        full_d[ld_bank_q] = 1'b1;
        ld_bank_d         = ~ld_bank_q;
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
      end
    end
    if (out_xfer) begin
      if (rd_addr_q == ADDR_LAST) begin
        rd_addr_d = '0;
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d         = '0;
          full_d[rp_bank_q] = 1'b0;
          rp_bank_d         = ~rp_bank_q;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end else begin
        rd_addr_d = rd_addr_q + AW'(1);
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ld_bank_q <= 1'b0;
      rp_bank_q <= 1'b0;
      full_q    <= 2'b00;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      ld_bank_q <= ld_bank_d;
      rp_bank_q <= rp_bank_d;
      full_q    <= full_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

`else

  cache_state_e state_q, state_d;

  // Reset gating keeps both strobes low for the whole time ap_rst_n is asserted.
  assign input_V_read   = ap_rst_n && (state_q == ST_LOAD) && input_V_empty_n;
  assign output_V_write = ap_rst_n && (state_q == ST_REPLAY) && output_V_full_n;
  assign in_xfer        = input_V_read;
  assign out_xfer       = output_V_write;

  weight_bank #(.KERN_SIZE(KERN_SIZE), .DATA_W(DATA_W)) u_bank (
    .clk   (ap_clk),
    .we    (in_xfer),
    .waddr (wr_addr_q),
    .wdata (input_V_dout),
    .raddr (rd_addr_q),
    .rdata (output_V_din)
  );

  // Strict alternation: fill all KERN_SIZE words, then replay REPLAYS times.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rep_cnt_d = rep_cnt_q;
    if (in_xfer) begin
      if (wr_addr_q == ADDR_LAST) begin
        wr_addr_d = '0;
        state_d   = ST_REPLAY;
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
      end
    end
    if (out_xfer) begin
      if (rd_addr_q == ADDR_LAST) begin
        rd_addr_d = '0;
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          state_d   = ST_LOAD;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end else begin
        rd_addr_d = rd_addr_q + AW'(1);
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_LOAD;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

`endif

endmodule
